noc_port_requester: RTL and testbench
=====================================

# noc_port_requester

Per-input-port requester for the 5-port NoC router: buffers incoming flits, decodes packet headers, and drives the `req`/`flit_id`/`length` inputs of the router arbiter for its port. It consumes that port's one-hot grant bit, forwards granted flits to the crossbar, and re-requests when the arbiter's timer revokes a grant mid-packet. One instance sits on each of the L, N, E, W and S inputs.

## Interface
Parameters:
- DATA_W, 32, flit payload width; must be ≥ 12.
- DEPTH, 4, input FIFO depth in flits; a power of 2, ≥ 2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  an upstream flit is offered.
- in_flit_id  in  3  flit type: 3'b001 header, 3'b010 body, 3'b100 tail.
- in_data  in  DATA_W  flit payload; on a header, bits [11:0] carry the packet length.
- in_ready  out  1  FIFO not full; a flit is accepted when in_valid & in_ready.
- grant  in  1  this port's bit of the arbiter's nextstate (the one-hot grant).
- req  out  1  request to the arbiter.
- flit_id  out  3  flit_id of the FIFO head; 3'b000 when the FIFO is empty.
- length  out  12  length field of the current packet's header.
- out_valid  out  1  a flit is forwarded this cycle.
- out_flit_id  out  3  flit_id of the forwarded flit.
- out_data  out  DATA_W  payload of the forwarded flit.
- err  out  1  sticky length/framing error (see Configuration).

## Operation
- FIFO: DEPTH entries, each {flit_id, data}.
  - Read/write pointers are log2(DEPTH)+1 bits.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Simultaneous push and pop while full is not permitted: in_ready is low when full, regardless of pop.
- FSM states: IDLE and ACTIVE.
- IDLE:
  - req=0.
  - If the FIFO head is a header, latch the head's data[11:0] into `length`, then go to ACTIVE next cycle.
  - If the head is a non-header flit, pop and discard it. err sets if enabled.
- ACTIVE:
  - req=1 for the whole packet, including bubbles when the FIFO is empty.
  - pop = grant & !empty; out_valid = pop; out_flit_id and out_data show the FIFO head (combinational).
  - When grant falls mid-packet (arbiter timer expired or higher-priority hand-off), hold the head flit and keep req=1 until grant returns.
  - Popping the tail returns the FSM to IDLE next cycle.
- Flit counter (12-bit):
  - Cleared on entry to ACTIVE.
  - Incremented on each pop.
  - Saturates at 12'hFFF.
- The flit_id output mirrors the head, so the arbiter's timer loads `length` when the header is at the head.
- A length of 0 is legal; the packet is still framed by its tail flit.

## Timing
- Reset values:
  - FSM = IDLE; pointers = 0; counter = 0.
  - req=0, length=0, flit_id=3'b000, out_valid=0, in_ready=1, err=0.
- Reset asserted mid-packet discards all buffered flits immediately, without waiting for a clock edge.
- Latency:
  - A flit written at edge N is visible at the head after edge N.
  - For a header, req rises after edge N+1.
  - The first out_valid occurs in the cycle grant is high, at the earliest in cycle N+2.
- The arbiter grant arrives combinationally from req in the same cycle. The block has no combinational path from grant to req.
- On the tail-pop edge, req is still 1 in that cycle. In the following cycle req=0 (IDLE) unless a new header is already at the head, in which case req returns to 1 one cycle later.
- Throughput: one flit per cycle while grant=1 and the FIFO is non-empty.

## Configuration
- REQ_LEN_CHECK_EN defined:
  - err sets, and stays set until reset, when either of these occurs:
    - a tail is popped with counter+1 ≠ length;
    - a non-header flit reaches the head in IDLE;
    - a header reaches the head in ACTIVE.
  - A header in ACTIVE is treated as an implicit tail: the FSM returns to IDLE without popping it.
- REQ_LEN_CHECK_EN undefined:
  - err is tied to 0 and no counter comparison logic is built.
  - A header in ACTIVE is forwarded as an ordinary flit.

## Test plan
- Reset, then write header(len=3), body, tail with grant held at 1 → req rises 2 cycles after the header write; out_valid for 3 consecutive cycles with ids 001, 010, 100; req=0 after the tail; err=0.
- Same packet with grant dropped for 4 cycles after the header pops → body held, no pop, req stays 1; forwarding resumes when grant returns, with data intact.
- Write 5 flits back-to-back with grant=0 and DEPTH=4 → in_ready=0 after the 4th accept; 5th accepted only after the first pop.
- Header(len=5) followed by a tail after 1 body, with the macro defined → err=1 at the tail pop and stays high; with the macro undefined, err=0.
- Assert rst mid-packet after 2 flits are forwarded → req, out_valid, and in_ready=1 return to reset values asynchronously; a following clean packet forwards correctly.
- Two packets back-to-back in the FIFO, grant=1 → one idle cycle with req=0, then the second header forwards; length updates to the second header's value.

Source files
------------

// File: rtl/noc_port_requester.sv
// Per-input-port requester for the 5-port NoC router.
// Buffers incoming flits in a small FIFO, frames packets by header/tail,
// requests the arbiter while a packet is in flight and forwards granted flits.
// Optional feature macro: REQ_LEN_CHECK_EN enables the sticky length/framing
// error flag and treats a stray header mid-packet as an implicit tail.
module noc_port_requester #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [2:0]        in_flit_id,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              out_valid,
  output logic [2:0]        out_flit_id,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] FidHdr  = 3'b001;
  localparam logic [2:0] FidTail = 3'b100;

  typedef enum logic {StIdle, StActive} state_e;

  state_e            state_q;
  logic              req_q;
  logic [11:0]       length_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [2:0]        mem_id_q   [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic              empty, full, push, pop, implicit_tail;
  logic [2:0]        head_id;
  logic [DATA_W-1:0] head_data;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = in_valid & ~full;
  assign head_id   = mem_id_q[rd_ptr_q[AW-1:0]];
  assign head_data = mem_data_q[rd_ptr_q[AW-1:0]];

`ifdef REQ_LEN_CHECK_EN
  logic [11:0] cnt_q;
  logic        err_q;
`endif

  // Pop decision: discard strays in idle, forward on grant while active.
  always_comb begin
    pop           = 1'b0;
    implicit_tail = 1'b0;
    if (!empty) begin
      if (state_q == StIdle) begin
        pop = (head_id != FidHdr);
      end else begin
`ifdef REQ_LEN_CHECK_EN
        // cnt_q != 0 means this packet's own header has already gone out
        implicit_tail = (head_id == FidHdr) && (cnt_q != 12'd0);
`endif
        pop = grant & ~implicit_tail;
      end
    end
  end

  // FIFO storage; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id_q[wr_ptr_q[AW-1:0]]   <= in_flit_id;
      mem_data_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Packet framing FSM with registered req and latched length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      req_q    <= 1'b0;
      length_q <= 12'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!empty && head_id == FidHdr) begin
            length_q <= head_data[11:0];
            state_q  <= StActive;
            req_q    <= 1'b1;
          end
        end
        StActive: begin
          if (implicit_tail || (pop && head_id == FidTail)) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_LEN_CHECK_EN
  // Flit counter and sticky framing error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 12'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        if (!empty && head_id == FidHdr) cnt_q <= 12'd0;
        if (pop) err_q <= 1'b1;
      end else begin
        if (pop && cnt_q != 12'hFFF) cnt_q <= cnt_q + 12'd1;
        if (implicit_tail) err_q <= 1'b1;
        if (pop && head_id == FidTail &&
            ({1'b0, cnt_q} + 13'd1 != {1'b0, length_q})) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready    = ~full;
  assign req         = req_q;
  assign length      = length_q;
  assign flit_id     = empty ? 3'b000 : head_id;
  assign out_valid   = (state_q == StActive) & pop;
  assign out_flit_id = head_id;
  assign out_data    = head_data;

endmodule

// File: tb/tb_noc_port_requester.sv
// Testbench for noc_port_requester: directed vector table, hand-written
// corner-case sequences and randomized traffic against a queue-based model.
module tb_noc_port_requester;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [2:0]  HDR = 3'b001;
  localparam logic [2:0]  BDY = 3'b010;
  localparam logic [2:0]  TL  = 3'b100;
`ifdef REQ_LEN_CHECK_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [2:0]        in_flit_id;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic              out_valid;
  logic [2:0]        out_flit_id;
  logic [DATA_W-1:0] out_data;
  logic              err;

  noc_port_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit_id(in_flit_id),
    .in_data(in_data), .in_ready(in_ready), .grant(grant), .req(req),
    .flit_id(flit_id), .length(length), .out_valid(out_valid),
    .out_flit_id(out_flit_id), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO as a queue plus "packet open" bit.
  typedef struct packed {
    logic [2:0]        id;
    logic [DATA_W-1:0] data;
  } flit_t;
  flit_t       mq[$];
  bit          m_act;
  logic [11:0] m_len;
  int          m_cnt;
  bit          m_err;

  // Values sampled in the last cycle, for constant checks by callers.
  logic s_req, s_ov, s_rdy;
  logic [2:0] s_oid;

  typedef struct {
    logic              v;
    logic [2:0]        id;
    logic [DATA_W-1:0] d;
    logic              g;
    logic              e_req;
    logic              e_ov;
    logic [2:0]        e_oid;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_act = 1'b0;
    m_len = 12'd0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  function automatic bit m_pop();
    if (mq.size() == 0) return 1'b0;
    if (!m_act) return mq[0].id != HDR;
    if (Chk && mq[0].id == HDR && m_cnt != 0) return 1'b0;
    return grant;
  endfunction

  // One clock cycle: drive, compare against model, clock, advance model.
  task automatic cycle(input logic v, input logic [2:0] id, input logic [DATA_W-1:0] d,
                       input logic g);
    bit    pop, acc;
    flit_t f;
    in_valid = v; in_flit_id = id; in_data = d; grant = g;
    #3;
    pop = m_pop();
    acc = v && (mq.size() < DEPTH);
    s_req = req; s_ov = out_valid; s_rdy = in_ready; s_oid = out_flit_id;
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("req", req, m_act);
    chk("flit_id", flit_id, (mq.size() != 0) ? mq[0].id : 3'b000);
    chk("length", length, m_len);
    chk("err", err, m_err);
    chk("out_valid", out_valid, m_act && pop);
    if (m_act && pop) begin
      chk("out_flit_id", out_flit_id, mq[0].id);
      chk("out_data", out_data, mq[0].data);
    end
    @(posedge clk);
    if (!m_act) begin
      if (mq.size() != 0 && mq[0].id == HDR) begin
        m_len = mq[0].data[11:0];
        m_act = 1'b1;
        m_cnt = 0;
      end else if (pop && Chk) begin
        m_err = 1'b1;
      end
    end else if (Chk && mq.size() != 0 && mq[0].id == HDR && m_cnt != 0) begin
      m_err = 1'b1;
      m_act = 1'b0;
    end else if (pop) begin
      if (mq[0].id == TL) begin
        if (Chk && (m_cnt + 1 != int'(m_len))) m_err = 1'b1;
        m_act = 1'b0;
      end
      if (m_cnt < 4095) m_cnt++;
    end
    if (pop) void'(mq.pop_front());
    if (acc) begin
      f.id = id;
      f.data = d;
      mq.push_back(f);
    end
    #1;
  endtask

  task automatic idle(input int n, input logic g);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'b000, '0, g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; in_flit_id = 3'b000; in_data = '0; grant = 1'b0;
    do_reset();

    // Reset state.
    #2;
    chk("rst_req", req, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_flit_id", flit_id, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_length", length, 12'd0);
    chk("rst_err", err, 1'b0);
    #1;

    // Basic packet, grant held high.
    tbl[0] = '{1'b1, HDR, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[1] = '{1'b1, BDY, 32'hB0D1_0001, 1'b1, 1'b0, 1'b0, 3'b000};
    tbl[2] = '{1'b1, TL,  32'h7A11_0002, 1'b1, 1'b1, 1'b1, HDR};
    tbl[3] = '{1'b0, 3'b000, 32'h0,      1'b1, 1'b1, 1'b1, BDY};
    tbl[4] = '{1'b0, 3'b000, 32'h0,      1'b1, 1'b1, 1'b1, TL};
    tbl[5] = '{1'b0, 3'b000, 32'h0,      1'b1, 1'b0, 1'b0, 3'b000};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].g);
      chk($sformatf("vec%0d_req", i), s_req, tbl[i].e_req);
      chk($sformatf("vec%0d_ov", i), s_ov, tbl[i].e_ov);
      if (tbl[i].e_ov) chk($sformatf("vec%0d_oid", i), s_oid, tbl[i].e_oid);
    end
    chk("basic_err", err, 1'b0);

    // Grant revoked for 4 cycles after the header pops.
    cycle(1'b1, HDR, 32'h0000_0003, 1'b0);
    cycle(1'b1, BDY, 32'hCAFE_0001, 1'b0);
    cycle(1'b1, TL,  32'hCAFE_0002, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 3'b000, '0, 1'b0);
      chk("drop_ov", s_ov, 1'b0);
      chk("drop_req", s_req, 1'b1);
    end
    idle(3, 1'b1);

    // FIFO fill with grant low: 5th flit waits for the first pop.
    cycle(1'b1, HDR, 32'h0000_0005, 1'b0);
    cycle(1'b1, BDY, 32'h1111_0001, 1'b0);
    cycle(1'b1, BDY, 32'h1111_0002, 1'b0);
    cycle(1'b1, BDY, 32'h1111_0003, 1'b0);
    cycle(1'b1, TL,  32'h1111_0004, 1'b0);
    chk("full_ready", s_rdy, 1'b0);
    cycle(1'b1, TL,  32'h1111_0004, 1'b0);
    cycle(1'b1, TL,  32'h1111_0004, 1'b1);
    cycle(1'b1, TL,  32'h1111_0004, 1'b1);
    chk("full_ready_after_pop", s_rdy, 1'b1);
    idle(6, 1'b1);

    // Length mismatch: header says 5, packet carries 3 flits.
    cycle(1'b1, HDR, 32'h0000_0005, 1'b1);
    cycle(1'b1, BDY, 32'h2222_0001, 1'b1);
    cycle(1'b1, TL,  32'h2222_0002, 1'b1);
    idle(3, 1'b1);
    chk("len_err", err, Chk);
    idle(2, 1'b0);
    chk("len_err_sticky", err, Chk);

    // Asynchronous reset after two flits have been forwarded.
    cycle(1'b1, HDR, 32'h0000_0004, 1'b1);
    cycle(1'b1, BDY, 32'h3333_0001, 1'b1);
    cycle(1'b1, BDY, 32'h3333_0002, 1'b1);
    cycle(1'b1, TL,  32'h3333_0003, 1'b1);
    in_valid = 1'b0; grant = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", req, 1'b0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_flit_id", flit_id, 3'b000);
    chk("arst_err", err, 1'b0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, HDR, 32'h0000_0003, 1'b1);
    cycle(1'b1, BDY, 32'h4444_0001, 1'b1);
    cycle(1'b1, TL,  32'h4444_0002, 1'b1);
    idle(3, 1'b1);

    // Two packets queued back-to-back.
    cycle(1'b1, HDR, 32'h0000_0002, 1'b0);
    cycle(1'b1, TL,  32'h5555_0001, 1'b0);
    cycle(1'b1, HDR, 32'h0000_0003, 1'b0);
    cycle(1'b1, BDY, 32'h5555_0002, 1'b1);
    cycle(1'b1, TL,  32'h5555_0003, 1'b1);
    idle(8, 1'b1);
    chk("b2b_length", length, 12'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [2:0]  id;
      logic [DATA_W-1:0] d;
      r = $urandom_range(0, 9);
      id = (r < 2) ? HDR : (r < 7) ? BDY : TL;
      d = $urandom;
      if (id == HDR) d[11:0] = 12'($urandom_range(0, 6));
      cycle(($urandom_range(0, 3) != 0), id, d, ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
